// File: rtl/lbuf_pkg.sv
// Shared types and default geometry for the line-buffer sequencer and the
// line buffer it drives. Keeping the defaults here lets the buffer instance
// and its controller agree on one set of numbers.
//   lbuf_state_t  : sequencer state encoding
//   LBUF_*        : default screen geometry and window depth
//   lines_width() : width of a counter that holds 0..depth-1
package lbuf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } lbuf_state_t;

  localparam int LBUF_SCREENWIDTH  = 1600;
  localparam int LBUF_SCREENHEIGHT = 900;
  localparam int LBUF_BUF_DEPTH    = 3;
  localparam int LBUF_XW           = 11;
  localparam int LBUF_YW           = 10;

  // A depth of 2 still needs one bit to count 0..1.
  function automatic int lines_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/line_buffer_ctrl_edge_det.sv
// One-bit edge detector with a single history register.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_d        : level input
//   o_rise     : i_d high now, low last cycle
//   o_fall     : i_d low now, high last cycle
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_d;

  // Previous-cycle copy of the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d <= 1'b0;
    end else begin
      r_d <= i_d;
    end
  end

  assign o_rise = i_d & ~r_d;
  assign o_fall = ~i_d & r_d;

endmodule

// File: rtl/line_buffer_ctrl.sv
// Sequencer for the BUF_DEPTH-line video buffer. Turns dv/vs timing into the
// buffer's line_end (address hold), tracks pixel/line position and flags
// when the row window is fully populated.
// Ports:
//   clk, rst_n    : pixel clock, asynchronous active-low reset
//   dv_i          : active-video pixel valid
//   hs_i          : hsync (informational only)
//   vs_i          : vsync, rising edge starts a frame
//   line_end_o    : holds buffer address at 0 outside active pixels
//   win_valid_o   : window valid, one cycle after dv_i
//   x_o, y_o      : column / newest row of the window, aligned with win_valid_o
//   frame_done_o  : one-cycle pulse after the last line of a frame
//   len_err_o     : sticky line-length error
// Optional feature: LBUF_LEN_CHECK_EN enables line-length checking; without
// it len_err_o stays 0 and lines are counted regardless of length.
module line_buffer_ctrl
  import lbuf_pkg::*;
#(
  parameter int SCREENWIDTH  = LBUF_SCREENWIDTH,
  parameter int SCREENHEIGHT = LBUF_SCREENHEIGHT,
  parameter int BUF_DEPTH    = LBUF_BUF_DEPTH,
  parameter int XW           = LBUF_XW,
  parameter int YW           = LBUF_YW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dv_i,
  input  logic          hs_i,
  input  logic          vs_i,
  output logic          line_end_o,
  output logic          win_valid_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          frame_done_o,
  output logic          len_err_o
);

  localparam int               LW         = lines_width(BUF_DEPTH);
  localparam logic [LW-1:0]    LINES_MAX  = LW'(BUF_DEPTH - 1);
  // Ending the line with this count fills the last row, so the next line streams.
  localparam logic [LW-1:0]    LINES_FULL = LW'(BUF_DEPTH - 2);
  localparam logic [XW-1:0]    PX_MAX     = {XW{1'b1}};
  localparam logic [XW-1:0]    PX_LINE    = XW'(SCREENWIDTH);
  localparam logic [YW-1:0]    Y_LAST     = YW'(SCREENHEIGHT - 1);

  lbuf_state_t   r_state, w_state_nxt;
  logic [LW-1:0] r_lines, w_lines_nxt;
  logic [YW-1:0] r_y, w_y_nxt;
  logic [XW-1:0] r_px, w_px_nxt;
  logic          r_len_err, w_len_err_nxt;
  logic          r_frame_done, w_frame_done_nxt;
  logic          r_win_valid;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y_o;

  logic w_dv_rise, w_dv_fall, w_vs_rise, w_vs_fall;
  logic w_active, w_bad_len;
  logic w_unused;

  edge_det u_dv_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (dv_i),
    .o_rise (w_dv_rise),
    .o_fall (w_dv_fall)
  );

  edge_det u_vs_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (vs_i),
    .o_rise (w_vs_rise),
    .o_fall (w_vs_fall)
  );

  assign w_active = (r_state != IDLE);

`ifdef LBUF_LEN_CHECK_EN
  assign w_bad_len = (r_px != PX_LINE);
  assign w_unused  = ^{hs_i, w_dv_rise, w_vs_fall};
`else
  assign w_bad_len = 1'b0;
  assign w_unused  = ^{hs_i, w_dv_rise, w_vs_fall, PX_LINE};
`endif

  // Combinational so the buffer sees address 0 on the first pixel of each line.
  assign line_end_o = ~dv_i | (r_state == IDLE) | ~rst_n;

  // Next-state and counter update; a vs rise overrides any end of line.
  always_comb begin
    w_state_nxt      = r_state;
    w_lines_nxt      = r_lines;
    w_y_nxt          = r_y;
    w_px_nxt         = r_px;
    w_len_err_nxt    = r_len_err;
    w_frame_done_nxt = 1'b0;
    if (w_vs_rise) begin
      w_state_nxt = FILL;
      w_lines_nxt = {LW{1'b0}};
      w_y_nxt     = {YW{1'b0}};
      w_px_nxt    = {XW{1'b0}};
    end else if (w_active && w_dv_fall) begin
      w_px_nxt = {XW{1'b0}};
      w_y_nxt  = (r_y == Y_LAST) ? r_y : r_y + YW'(1);
      if (w_bad_len) begin
        w_len_err_nxt = 1'b1;
      end else begin
        w_len_err_nxt = r_len_err;
      end
      case (r_state)
        FILL: begin
          w_lines_nxt = (r_lines == LINES_MAX) ? r_lines : r_lines + LW'(1);
          if (r_lines >= LINES_FULL) begin
            w_state_nxt = STREAM;
          end else begin
            w_state_nxt = FILL;
          end
        end
        STREAM: begin
          if (w_bad_len) begin
            // Re-prime the window after a malformed line.
            w_state_nxt = FILL;
            w_lines_nxt = {LW{1'b0}};
          end else if (r_y == Y_LAST) begin
            w_state_nxt      = IDLE;
            w_frame_done_nxt = 1'b1;
          end else begin
            w_state_nxt = STREAM;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end else if (w_active && dv_i) begin
      w_px_nxt = (r_px == PX_MAX) ? r_px : r_px + XW'(1);
    end else begin
      w_px_nxt = r_px;
    end
  end

  // Sequencer state and position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_lines      <= {LW{1'b0}};
      r_y          <= {YW{1'b0}};
      r_px         <= {XW{1'b0}};
      r_len_err    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lines      <= w_lines_nxt;
      r_y          <= w_y_nxt;
      r_px         <= w_px_nxt;
      r_len_err    <= w_len_err_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  // Window outputs, delayed one cycle to line up with the buffer's dv_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_valid <= 1'b0;
      r_x         <= {XW{1'b0}};
      r_y_o       <= {YW{1'b0}};
    end else begin
      r_win_valid <= dv_i && (r_state == STREAM);
      r_x         <= r_px;
      r_y_o       <= r_y;
    end
  end

  assign win_valid_o  = r_win_valid;
  assign x_o          = r_x;
  assign y_o          = r_y_o;
  assign frame_done_o = r_frame_done;
  assign len_err_o    = r_len_err;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl on a reduced 16x12 screen, depth 3.
// Expected window outputs are queued as each cycle is driven and compared
// when the DUT presents them one cycle later.
module tb_line_buffer_ctrl;
  import lbuf_pkg::*;

  localparam int W  = 16;
  localparam int H  = 12;
  localparam int D  = 3;
  localparam int XW = 5;
  localparam int YW = 4;

  logic          clk = 1'b0;
  logic          rst_n, dv_i, hs_i, vs_i;
  logic          line_end_o, win_valid_o, frame_done_o, len_err_o;
  logic [XW-1:0] x_o;
  logic [YW-1:0] y_o;

  line_buffer_ctrl #(
    .SCREENWIDTH (W), .SCREENHEIGHT (H), .BUF_DEPTH (D), .XW (XW), .YW (YW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dv_i         (dv_i),
    .hs_i         (hs_i),
    .vs_i         (vs_i),
    .line_end_o   (line_end_o),
    .win_valid_o  (win_valid_o),
    .x_o          (x_o),
    .y_o          (y_o),
    .frame_done_o (frame_done_o),
    .len_err_o    (len_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int x;
    int y;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   tb_idle;
  bit   exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive dv/hs, check line_end, queue the expected window output,
  // then compare it after the edge.
  task automatic pix(input bit dv, input bit hs, input exp_t e, input bit exp_fd);
    exp_t got;
    dv_i = dv;
    hs_i = hs;
    #1;
    check("line_end", {31'd0, line_end_o}, {31'd0, (~dv) | tb_idle});
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("win_valid", {31'd0, win_valid_o}, {31'd0, got.v});
    if (got.v) begin
      check("x", {27'd0, x_o}, got.x);
      check("y", {28'd0, y_o}, got.y);
    end
    check("frame_done", {31'd0, frame_done_o}, {31'd0, exp_fd});
  endtask

  task automatic run_line(input int len, input bit v, input int y, input bit last);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      e.v = v; e.x = i; e.y = y;
      pix(1'b1, 1'b0, e, 1'b0);
    end
    for (int b = 0; b < 4; b++) begin
      e.v = 1'b0; e.x = 0; e.y = 0;
      pix(1'b0, (b == 1), e, (last && b == 0));
      if (last && b == 0) tb_idle = 1'b1;
    end
    check("len_err", {31'd0, len_err_o}, {31'd0, exp_err});
  endtask

  task automatic vs_pulse();
    exp_t e;
    e.v = 1'b0; e.x = 0; e.y = 0;
    vs_i = 1'b1;
    pix(1'b0, 1'b0, e, 1'b0);
    tb_idle = 1'b0;
    vs_i = 1'b0;
    pix(1'b0, 1'b0, e, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_win_valid"},  {31'd0, win_valid_o},  32'd0);
    check({tag, "_x"},          {27'd0, x_o},          32'd0);
    check({tag, "_y"},          {28'd0, y_o},          32'd0);
    check({tag, "_frame_done"}, {31'd0, frame_done_o}, 32'd0);
    check({tag, "_len_err"},    {31'd0, len_err_o},    32'd0);
    check({tag, "_line_end"},   {31'd0, line_end_o},   32'd1);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
    tb_idle = 1'b1; exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full frame: rows 0..D-2 fill, later rows stream, frame_done after the last.
    vs_pulse();
    for (int l = 0; l < H; l++) run_line(W, (l >= D - 1), l, (l == H - 1));

    // dv while idle is ignored and line_end stays high.
    run_line(W, 1'b0, 0, 1'b0);

    // vs rise mid-frame restarts the window.
    vs_pulse();
    for (int l = 0; l < 6; l++) run_line(W, (l >= D - 1), l, 1'b0);
    vs_pulse();
    run_line(W, 1'b0, 0, 1'b0);
    run_line(W, 1'b0, 1, 1'b0);
    run_line(W, 1'b1, 2, 1'b0);

    // Short line while streaming.
`ifdef LBUF_LEN_CHECK_EN
    exp_err = 1'b1;
    run_line(W - 1, 1'b1, 3, 1'b0);
    run_line(W, 1'b0, 4, 1'b0);
    run_line(W, 1'b0, 5, 1'b0);
    run_line(W, 1'b1, 6, 1'b0);
`else
    run_line(W - 1, 1'b1, 3, 1'b0);
    run_line(W, 1'b1, 4, 1'b0);
    run_line(W, 1'b1, 5, 1'b0);
    run_line(W, 1'b1, 6, 1'b0);
`endif

    // Asynchronous reset in the middle of a streaming line.
    for (int i = 0; i < 5; i++) begin
      e.v = 1'b1; e.x = i; e.y = 7;
      pix(1'b1, 1'b0, e, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midline_reset");
    exp_err = 1'b0;
    tb_idle = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_line(W - 5, 1'b0, 0, 1'b0);

    // Resumes on the next vs rise.
    vs_pulse();
    run_line(W, 1'b0, 0, 1'b0);
    run_line(W, 1'b0, 1, 1'b0);
    run_line(W, 1'b1, 2, 1'b0);

    check("scoreboard_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
